// File: rtl/sound_pkg.sv
// sound_pkg: shared mixer widths, panning modes and the sum-to-sample conversion.
package sound_pkg;
    typedef enum logic [1:0] {ABC = 2'b00, ACB = 2'b01, MONO = 2'b10} stereo_mode_t;
    localparam int MIX_W = 11;
    localparam int MIX_SHIFT = 5;
    // Unsigned mixer sum to offset-binary-free two's complement: silence is most negative.
    function automatic logic [15:0] to_word(input logic [MIX_W-1:0] s);
        return {s, {MIX_SHIFT{1'b0}}} ^ 16'h8000;
    endfunction
endpackage

// File: rtl/sound_mixer.sv
// sound_mixer: registered stereo mix of the six AY channel levels.
module sound_mixer
    import sound_pkg::*;
(
    input  logic             clk28,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             mute,
    input  logic [7:0]       ay_a0,
    input  logic [7:0]       ay_b0,
    input  logic [7:0]       ay_c0,
    input  logic [7:0]       ay_a1,
    input  logic [7:0]       ay_b1,
    input  logic [7:0]       ay_c1,
    output logic [MIX_W-1:0] left,
    output logic [MIX_W-1:0] right
);
    logic [MIX_W-1:0] sa, sb, sc, mono, l_nx, r_nx;
    assign sa = MIX_W'(ay_a0) + MIX_W'(ay_a1);
    assign sb = MIX_W'(ay_b0) + MIX_W'(ay_b1);
    assign sc = MIX_W'(ay_c0) + MIX_W'(ay_c1);
    assign mono = sa + sb + sc;
    always_comb begin
        l_nx = mute ? '0 : mode[1] ? mono : (mode == ACB) ? (sa << 1) + sc : (sa << 1) + sb;
        r_nx = mute ? '0 : mode[1] ? mono : (mode == ACB) ? (sb << 1) + sc : (sc << 1) + sb;
    end
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            left  <= '0;
            right <= '0;
        end else begin
            left  <= l_nx;
            right <= r_nx;
        end
    end
endmodule

// File: rtl/sound_i2s_tx.sv
// sound_i2s_tx: AY stereo mixer feeding an I2S serialiser (BCK, LRCK, DAT) from clk28.
module sound_i2s_tx
    import sound_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int BCK_HALF    = 7
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       mute,
    input  logic [7:0] ay_a0,
    input  logic [7:0] ay_b0,
    input  logic [7:0] ay_c0,
    input  logic [7:0] ay_a1,
    input  logic [7:0] ay_b1,
    input  logic [7:0] ay_c1,
    output logic       i2s_bck,
    output logic       i2s_lrck,
    output logic       i2s_dat,
    output logic       frame
);
    localparam int N  = 2 * SAMPLE_BITS;
    localparam int NW = $clog2(N);
    localparam int CW = $clog2(BCK_HALF + 1);
    logic [MIX_W-1:0] left, right;
    logic [15:0]      lw, rw;
    logic [CW-1:0]    cnt;
    logic [NW-1:0]    n, n_nx;
    logic [N-1:0]     shreg, sh_nx;
    logic             tick, fall, load;
    sound_mixer u_mixer (
        .clk28(clk28), .rst_n(rst_n), .mode(mode), .mute(mute),
        .ay_a0(ay_a0), .ay_b0(ay_b0), .ay_c0(ay_c0),
        .ay_a1(ay_a1), .ay_b1(ay_b1), .ay_c1(ay_c1),
        .left(left), .right(right)
    );
    assign lw    = to_word(left);
    assign rw    = to_word(right);
    assign tick  = cnt == CW'(BCK_HALF - 1);
    assign fall  = tick && i2s_bck;
    assign n_nx  = (n == NW'(N - 1)) ? '0 : n + 1'b1;
    assign load  = n_nx == '0;
    assign sh_nx = load ? {lw[15 -: SAMPLE_BITS], rw[15 -: SAMPLE_BITS]} : {shreg[N-2:0], 1'b0};
    // Everything serial moves on the BCK falling event so the DAC sees stable data on the rise.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            n        <= NW'(N - 1);
            shreg    <= '0;
            i2s_bck  <= 1'b0;
            i2s_lrck <= 1'b0;
            i2s_dat  <= 1'b0;
            frame    <= 1'b0;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            frame <= fall && load;
            if (tick)
                i2s_bck <= ~i2s_bck;
            if (fall) begin
                n        <= n_nx;
                shreg    <= sh_nx;
                i2s_dat  <= sh_nx[N-1];
                i2s_lrck <= (n_nx >= NW'(SAMPLE_BITS - 1)) && (n_nx <= NW'(N - 2));
            end
        end
    end
endmodule

// File: tb/tb_sound_i2s_tx.sv
// tb_sound_i2s_tx: table-driven vectors decoded from the DAC side against a frame scoreboard.
module tb_sound_i2s_tx;
    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       mute = 1'b0;
    logic [7:0] ay_a0 = 8'd0, ay_b0 = 8'd0, ay_c0 = 8'd0, ay_a1 = 8'd0, ay_b1 = 8'd0, ay_c1 = 8'd0;
    logic [1:0] bck, lrck, dat, frm;
    int checks = 0, errors = 0;
    logic [31:0] sb[$];
    logic busy = 1'b0;

    always #5 clk28 = ~clk28;

    sound_i2s_tx #(.SAMPLE_BITS(16), .BCK_HALF(7)) dut0 (
        .clk28(clk28), .rst_n(rst_n), .mode(mode), .mute(mute),
        .ay_a0(ay_a0), .ay_b0(ay_b0), .ay_c0(ay_c0), .ay_a1(ay_a1), .ay_b1(ay_b1), .ay_c1(ay_c1),
        .i2s_bck(bck[0]), .i2s_lrck(lrck[0]), .i2s_dat(dat[0]), .frame(frm[0])
    );
    sound_i2s_tx #(.SAMPLE_BITS(16), .BCK_HALF(1)) dut1 (
        .clk28(clk28), .rst_n(rst_n), .mode(mode), .mute(mute),
        .ay_a0(ay_a0), .ay_b0(ay_b0), .ay_c0(ay_c0), .ay_a1(ay_a1), .ay_b1(ay_b1), .ay_c1(ay_c1),
        .i2s_bck(bck[1]), .i2s_lrck(lrck[1]), .i2s_dat(dat[1]), .frame(frm[1])
    );

    typedef struct {
        logic [1:0]  mode;
        logic        mute;
        logic [7:0]  a0, b0, c0, a1, b1, c1;
        logic [15:0] l, r;
    } vec_t;
    vec_t v[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // DAC-side decoder: 32 bits sampled on BCK rises after a frame pulse, compared to the popped entry.
    initial begin
        logic pb;
        logic [31:0] cur, got, lrp;
        int bits;
        pb = 1'b0;
        cur = '0;
        got = '0;
        lrp = '0;
        bits = 0;
        forever begin
            @(negedge clk28);
            if (!rst_n) begin
                busy = 1'b0;
                pb = 1'b0;
            end else begin
                if (!busy && frm[0] && sb.size() > 0) begin
                    cur = sb.pop_front();
                    busy = 1'b1;
                    bits = 0;
                end else if (busy && bck[0] && !pb) begin
                    got = {got[30:0], dat[0]};
                    lrp = {lrp[30:0], lrck[0]};
                    bits++;
                    if (bits == 32) begin
                        chk("left_word", {16'h0, got[31:16]}, {16'h0, cur[31:16]});
                        chk("right_word", {16'h0, got[15:0]}, {16'h0, cur[15:0]});
                        chk("lrck_pattern", lrp, 32'h0001_FFFE);
                        busy = 1'b0;
                    end
                end
                pb = bck[0];
            end
        end
    end

    task automatic wait_frame(input int d);
        int c = 0;
        do begin
            @(negedge clk28);
            c++;
        end while (!frm[d] && c < 2000);
        if (!frm[d]) timeout("wait_frame");
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((sb.size() != 0 || busy) && c < 5000) begin
            @(negedge clk28);
            c++;
        end
        if (sb.size() != 0 || busy) timeout("wait_idle");
    endtask

    task automatic set_in(input vec_t x);
        mode = x.mode; mute = x.mute;
        ay_a0 = x.a0; ay_b0 = x.b0; ay_c0 = x.c0;
        ay_a1 = x.a1; ay_b1 = x.b1; ay_c1 = x.c1;
    endtask

    task automatic run_vec(input vec_t x);
        wait_idle();
        wait_frame(0);
        @(negedge clk28);
        set_in(x);
        sb.push_back({x.l, x.r});
    endtask

    // Called right after reset release; inputs are ABC with ay_a0=255 so the left MSB is 1.
    task automatic startup();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk28);
            if (k == 2) chk("bh1_first_frame", {31'h0, frm[1]}, 32'h1);
            if (k == 6) chk("bck_low_c6", {31'h0, bck[0]}, 32'h0);
            if (k == 7) chk("bck_rise_c7", {31'h0, bck[0]}, 32'h1);
            if (k == 13) chk("c13_bck_frame", {30'h0, bck[0], frm[0]}, 32'h2);
            if (k == 14) chk("c14_bck_frame_lrck_dat", {28'h0, bck[0], frm[0], lrck[0], dat[0]}, 32'h5);
        end
    endtask

    task automatic lrck_timing(input int d, input int bh);
        int c = 0, tr = -1, tf = -1;
        wait_frame(d);
        do begin
            @(negedge clk28);
            c++;
            if (lrck[d] && tr < 0) tr = c;
            if (!lrck[d] && tr >= 0 && tf < 0) tf = c;
        end while (!frm[d] && c < 2000);
        chk("lrck_rise", tr, 15 * 2 * bh);
        chk("lrck_fall", tf, 31 * 2 * bh);
        chk("frame_period", c, 32 * 2 * bh);
    endtask

    initial begin
        vec_t boot;
        v[0] = '{2'b00, 1'b0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'hBFC0, 16'h8000};
        v[1] = '{2'b01, 1'b0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 16'h8C80, 16'h8C80};
        v[2] = '{2'b00, 1'b0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0, 16'h8000, 16'h9900};
        v[3] = '{2'b10, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 16'h3F40, 16'h3F40};
        v[4] = '{2'b11, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 16'h82A0, 16'h82A0};
        v[5] = '{2'b01, 1'b0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd10, 8'd3, 16'h8220, 16'h82E0};
        v[6] = '{2'b00, 1'b0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd200, 16'hBFC0, 16'hF1C0};
        v[7] = '{2'b00, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 16'h8000, 16'h8000};
        boot = v[0];
        set_in(boot);
        repeat (3) @(negedge clk28);
        chk("reset_outputs", {24'h0, bck, lrck, dat, frm}, 32'h0);
        sb.push_back({boot.l, boot.r});
        rst_n = 1'b1;
        startup();
        wait_idle();
        for (int i = 0; i < 8; i++) run_vec(v[i]);
        wait_idle();
        // Mute mid-frame: the frame already loaded keeps its samples.
        wait_frame(0);
        @(negedge clk28);
        set_in(v[3]);
        sb.push_back({16'h3F40, 16'h3F40});
        wait_frame(0);
        repeat (100) @(negedge clk28);
        mute = 1'b1;
        sb.push_back({16'h8000, 16'h8000});
        wait_idle();
        lrck_timing(0, 7);
        lrck_timing(1, 1);
        // Reset at n=20, while LRCK is high.
        wait_frame(0);
        repeat (283) @(negedge clk28);
        chk("pre_reset_lrck", {31'h0, lrck[0]}, 32'h1);
        set_in(boot);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {24'h0, bck, lrck, dat, frm}, 32'h0);
        repeat (2) @(negedge clk28);
        sb.push_back({boot.l, boot.r});
        rst_n = 1'b1;
        startup();
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sound_i2s_tx.md
# sound_i2s_tx

Audio sink for the turbosound block.
- Takes the six 8-bit AY channel levels (two chips × A/B/C) and mixes them into a stereo pair according to a selectable panning mode.
- Serialises the pair as a standard I2S stream (BCK, LRCK, DAT) to an external audio DAC.
- Sits between the sound sources and the board audio pins, clocked entirely from clk28.

## Interface
Parameters:
- SAMPLE_BITS, 16: bits per channel word; legal range 12..16.
- BCK_HALF, 7: clk28 cycles per BCK half-period; minimum 1. Default gives BCK = 2 MHz and frame rate 62.5 kHz.

Ports:
- clk28  in  1  system clock, 28 MHz; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  panning mode: 00 ABC, 01 ACB, 10 mono, 11 mono.
- mute  in  1  forces the mixer sums to zero.
- ay_a0, ay_b0, ay_c0, ay_a1, ay_b1, ay_c1  in  8 each  unsigned channel levels.
- i2s_bck  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left.
- i2s_dat  out  1  serial data, MSB first.
- frame  out  1  one-clk28 pulse when a new stereo sample is loaded.

## Operation
Mixer (registered every clk28, unsigned 11-bit sums, inputs zero-extended):
- ABC: L = 2·(A0+A1) + B0+B1; R = 2·(C0+C1) + B0+B1.
- ACB: L = 2·(A0+A1) + C0+C1; R = 2·(B0+B1) + C0+C1.
- Mono: L = R = A0+B0+C0+A1+B1+C1.
- Maximum sum is 1530 in every mode; no overflow is possible.
- mute=1 forces both sums to 0.

Conversion: word = ({sum,5'b0} ^ 16'h8000), keeping the top SAMPLE_BITS bits. Sum 0 maps to the most negative value.

Divider:
- cnt counts 0..BCK_HALF-1. At BCK_HALF-1 it wraps to 0 and i2s_bck toggles.
- A toggle from 1 to 0 is a "falling event".

Bit counter n, 0..2·SAMPLE_BITS-1, advances by 1 (mod 2·SAMPLE_BITS) on each falling event. With N = 2·SAMPLE_BITS, on each falling event:
- If new n == 0: load shreg ← {L_word, R_word} from the mixer register, and pulse frame.
- Otherwise: shift shreg left by one with zero fill.
- i2s_dat follows shreg MSB.
- i2s_lrck = 1 for new n in [SAMPLE_BITS-1, N-2], else 0.
- This is I2S one-BCK delay: LRCK changes one BCK before the MSB of each word.

Boundary conditions:
- mode and mute changes mid-frame take effect at the next load only.
- Changes to the ay_* inputs also take effect only at the next load.
- Reset asserted mid-frame aborts immediately. There is no partial-word completion.

## Timing
Reset values:
- i2s_bck=0, i2s_lrck=0, i2s_dat=0, frame=0.
- cnt=0, n=N-1, shreg=0, mixer register=0.

After reset:
- First BCK rise is at clk28 edge BCK_HALF.
- First falling event is at edge 2·BCK_HALF. It loads the frame, sets n=0, and pulses frame.

Outputs:
- All outputs are registered; DAT and LRCK change only on falling events.
- The DAC samples on the BCK rise, BCK_HALF cycles later.

Latency:
- ay_* inputs to mixer register: 1 clk28.
- A load uses the mixer value present at the falling-event edge.

Frame period = 2·BCK_HALF·N clk28 cycles (448 at defaults).

## Structure
- Package sound_pkg: the stereo_mode_t enum (ABC, ACB, MONO) and the constants MIX_W=11 and MIX_SHIFT=5.
- Sub-module sound_mixer: the six inputs, mode and mute in; registered L/R sums out.
- The I2S serialiser (divider, bit counter and shifter) lives in the top module.

## Test plan
- Reset: check the documented reset values. Release reset: BCK rises at cycle 7 and falls at cycle 14 with frame=1. LRCK=0 for the left word, and the first DAT bit is the left MSB.
- ABC, ay_a0=255, others 0: left word 0xBFC0 and right word 0x8000, checked by decoding 32 bits per frame from the DAC side.
- ACB, ay_c0=100: both words 0x8C80. Then switch to ABC with ay_c0=100: L=0x8000, R=0x9900.
- Mono, all inputs 255: both words 0x3F40. Assert mute mid-frame: the current frame is unchanged and the next frame is 0x8000/0x8000.
- LRCK protocol: LRCK rises on the falling event with n=15, exactly one BCK before the right MSB, and falls at n=31. Frame period is 448 clk28 cycles with SAMPLE_BITS=16 and BCK_HALF=7. Repeat with BCK_HALF=1.
- Reset asserted at n=20: all outputs return to reset values asynchronously. After release the sequence restarts exactly as in the first scenario.
